// File: rtl/alu_arb_pkg.sv
// Shared types for the ALU operand arbiter: requester count, index type, output-stage states.
package alu_arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef logic [IDX_W-1:0] req_idx_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_t;

  function automatic logic [N_REQ-1:0] idx_onehot(input req_idx_t idx);
    logic [N_REQ-1:0] one;
    one = {{(N_REQ-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/alu_operand_arbiter_rr4_picker.sv
// Combinational 4-way round-robin picker: scans last_ptr+1..last_ptr+4, restricted to the lock owner when locked.
// No state; winner is 0 when nothing is eligible.
module rr4_picker
  import alu_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_valid_i,
  input  req_idx_t         last_ptr_i,
  input  logic             lock_active_i,
  input  req_idx_t         owner_i,
  output req_idx_t         winner_o,
  output logic             any_valid_o
);

  logic [N_REQ-1:0] eligible;
  req_idx_t         cand;
  logic             found;

  always_comb begin
    eligible = req_valid_i;
    if (lock_active_i) begin
      eligible = req_valid_i & idx_onehot(owner_i);
    end
    winner_o = '0;
    found    = 1'b0;
    cand     = '0;
    // Offset 4 truncates to 0, so the last candidate is last_ptr itself.
    for (int i = 1; i <= N_REQ; i++) begin
      cand = last_ptr_i + req_idx_t'(i);
      if (!found && eligible[cand]) begin
        winner_o = cand;
        found    = 1'b1;
      end
    end
    any_valid_o = |eligible;
  end

endmodule

// File: rtl/alu_operand_arbiter.sv
// Round-robin share of one ALU operand path among 4 requesters; 1-cycle accept-to-out_valid_o, no bubble.
// Stalled output (out_valid_o & ~out_ready_i) deasserts every req_ready_o; ALU_ARB_LOCK_EN adds per-requester burst lock.
module alu_operand_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic [1:0]              sel_2bit_o,
  output logic                    out_valid_o,
  output logic [DATA_W-1:0]       out_data_o,
  output logic [1:0]              out_src_o,
  input  logic                    out_ready_i
`ifdef ALU_ARB_LOCK_EN
  ,
  input  logic [N_REQ-1:0]        req_lock_i
`endif
);

  arb_state_t        state_q, state_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  req_idx_t          out_src_q, out_src_d;
  req_idx_t          last_ptr_q, last_ptr_d;

  logic     lock_active;
  req_idx_t lock_owner;
  req_idx_t winner;
  logic     any_valid;
  logic     can_accept;
  logic     accept;

  rr4_picker u_picker (
    .req_valid_i   (req_valid_i),
    .last_ptr_i    (last_ptr_q),
    .lock_active_i (lock_active),
    .owner_i       (lock_owner),
    .winner_o      (winner),
    .any_valid_o   (any_valid)
  );

  assign can_accept = (state_q == ST_EMPTY) | out_ready_i;
  assign accept     = any_valid & can_accept;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    last_ptr_d  = last_ptr_q;
    req_ready_o = '0;
    if (accept) begin
      req_ready_o = idx_onehot(winner);
      out_data_d  = req_data_i[winner*DATA_W +: DATA_W];
      out_src_d   = winner;
      last_ptr_d  = winner;
    end
    case (state_q)
      ST_EMPTY: begin
        if (accept) state_d = ST_FULL;
      end
      ST_FULL: begin
        if (out_ready_i && !accept) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_EMPTY;
      out_data_q <= '0;
      out_src_q  <= '0;
      last_ptr_q <= req_idx_t'(N_REQ - 1);
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_src_q  <= out_src_d;
      last_ptr_q <= last_ptr_d;
    end
  end

`ifdef ALU_ARB_LOCK_EN
  logic     lock_active_q, lock_active_d;
  req_idx_t lock_owner_q, lock_owner_d;

  // While locked the picker only lets the owner win, so winner == owner on any accept.
  always_comb begin
    lock_active_d = lock_active_q;
    lock_owner_d  = lock_owner_q;
    if (accept) begin
      if (lock_active_q) begin
        lock_active_d = req_lock_i[winner];
      end else if (req_lock_i[winner]) begin
        lock_active_d = 1'b1;
        lock_owner_d  = winner;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_active_q <= 1'b0;
      lock_owner_q  <= '0;
    end else begin
      lock_active_q <= lock_active_d;
      lock_owner_q  <= lock_owner_d;
    end
  end

  assign lock_active = lock_active_q;
  assign lock_owner  = lock_owner_q;
`else
  assign lock_active = 1'b0;
  assign lock_owner  = '0;
`endif

  assign sel_2bit_o  = winner;
  assign out_valid_o = (state_q == ST_FULL);
  assign out_data_o  = out_data_q;
  assign out_src_o   = out_src_q;

endmodule

// File: tb/tb_alu_operand_arbiter.sv
// Directed bench for alu_operand_arbiter: round-robin order, lone requester, stall, drain, async reset, optional lock.
module tb_alu_operand_arbiter;

  localparam int DW = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req_valid;
  logic [4*DW-1:0] req_data;
  logic [3:0]     req_ready;
  logic [1:0]     sel;
  logic           out_valid;
  logic [DW-1:0]  out_data;
  logic [1:0]     out_src;
  logic           out_ready;
`ifdef ALU_ARB_LOCK_EN
  logic [3:0]     req_lock;
`endif

  int checks = 0;
  int errors = 0;

  alu_operand_arbiter #(.DATA_W(DW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .sel_2bit_o  (sel),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_src_o   (out_src),
    .out_ready_i (out_ready)
`ifdef ALU_ARB_LOCK_EN
    ,
    .req_lock_i  (req_lock)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input int k);
    return 32'hA5A5_0000 | 32'(k * 32'h0101);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'b0000;
    out_ready = 1'b1;
`ifdef ALU_ARB_LOCK_EN
    req_lock  = 4'b0000;
`endif
    for (int k = 0; k < 4; k++) req_data[k*DW +: DW] = word(k);

    #12;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_data",  out_data, 32'd0);
    check_eq("rst_src",   32'(out_src), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd0);

    // 1: all valid -> 0,1,2,3,0
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("rr_sel",   32'(sel), 32'(i % 4));
      check_eq("rr_ready", 32'(req_ready), 32'(4'b0001 << (i % 4)));
      @(posedge clk); #1;
      check_eq("rr_valid", 32'(out_valid), 32'd1);
      check_eq("rr_src",   32'(out_src), 32'(i % 4));
      check_eq("rr_data",  out_data, word(i % 4));
      @(negedge clk);
    end

    // 2: lone requester 2 wins repeatedly
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = 32'hDEAD_BEEF;
    for (int r = 0; r < 2; r++) begin
      #1;
      check_eq("lone_sel",   32'(sel), 32'd2);
      check_eq("lone_ready", 32'(req_ready), 32'b0100);
      @(posedge clk); #1;
      check_eq("lone_valid", 32'(out_valid), 32'd1);
      check_eq("lone_data",  out_data, 32'hDEAD_BEEF);
      check_eq("lone_src",   32'(out_src), 32'd2);
      @(negedge clk);
    end

    // 3: stall 5 cycles with reqs 1,3 pending
    out_ready = 1'b0;
    req_valid = 4'b1010;
    req_data[2*DW +: DW] = word(2);
    #1;
    check_eq("stall_sel", 32'(sel), 32'd3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      check_eq("stall_ready", 32'(req_ready), 32'd0);
      check_eq("stall_valid", 32'(out_valid), 32'd1);
      check_eq("stall_src",   32'(out_src), 32'd2);
      check_eq("stall_data",  out_data, 32'hDEAD_BEEF);
    end
    out_ready = 1'b1;
    #1;
    check_eq("unstall_ready", 32'(req_ready), 32'b1000);
    @(posedge clk); #1;
    check_eq("unstall_valid", 32'(out_valid), 32'd1);
    check_eq("unstall_src",   32'(out_src), 32'd3);
    check_eq("unstall_data",  out_data, word(3));
    @(negedge clk);

    // 4: drain to EMPTY
    req_valid = 4'b0000;
    out_ready = 1'b0;
    @(posedge clk); #1;
    check_eq("hold_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check_eq("drain_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check_eq("drain_valid", 32'(out_valid), 32'd0);
    @(negedge clk);

    // 5: async reset mid-stream; pointer restarts at 3 so req 0 wins
    req_valid = 4'b1111;
    @(posedge clk); #1;
    check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
    check_eq("pre_rst_src",   32'(out_src), 32'd0);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_data",  out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("post_rst_sel",   32'(sel), 32'd0);
    check_eq("post_rst_ready", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    check_eq("post_rst_src",  32'(out_src), 32'd0);
    check_eq("post_rst_data", out_data, word(0));
    @(negedge clk);

`ifdef ALU_ARB_LOCK_EN
    // 6: req 1 locks; 0 and 2 starved until unlock beat
    req_valid = 4'b0111;
    req_lock  = 4'b0010;
    for (int b = 0; b < 3; b++) begin
      #1;
      check_eq("lock_sel",   32'(sel), 32'd1);
      check_eq("lock_ready", 32'(req_ready), 32'b0010);
      @(posedge clk); #1;
      check_eq("lock_src", 32'(out_src), 32'd1);
      @(negedge clk);
    end
    req_valid = 4'b0101;
    #1;
    check_eq("lock_idle_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    req_valid = 4'b0111;
    req_lock  = 4'b0000;
    #1;
    check_eq("unlock_ready", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    check_eq("unlock_src", 32'(out_src), 32'd1);
    @(negedge clk); #1;
    check_eq("after_sel",   32'(sel), 32'd2);
    check_eq("after_ready", 32'(req_ready), 32'b0100);
    @(posedge clk); #1;
    check_eq("after_src",  32'(out_src), 32'd2);
    check_eq("after_data", out_data, word(2));
    @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
